// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, show-ahead or
// registered read data, synchronous flush and sticky overflow/underflow capture.
module sync_fifo_lvl #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned FWFT          = 1,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  wfull_o,
  output logic                  almost_full_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  rempty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level;
  logic                  full, empty, push, pop;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  // Status decodes from registered pointers only; request handling and next state.
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
               (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    push     = wr_en_i && !full && !flush_i;
    pop      = rd_en_i && !empty && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = clr_err_i ? 1'b0 : ovf_q;
    udf_d = clr_err_i ? 1'b0 : udf_q;
    if (wr_en_i && full)  ovf_d = 1'b1;
    if (rd_en_i && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array: write-only clocking, no reset.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata_i;
  end

  assign wfull_o        = full;
  assign rempty_o       = empty;
  assign level_o        = level;
  assign almost_full_o  = (level >= PW'(AFULL_THRESH));
  assign almost_empty_o = (level <= PW'(AEMPTY_THRESH));
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  if (FWFT != 0) begin : g_fwft
    assign rdata_o  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rvalid_o = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q;

    // Popped entry appears the cycle after the accepting edge; otherwise held.
    always_comb begin
      rdata_d = rdata_q;
      if (pop) rdata_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= pop;
      end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench: show-ahead and registered-read instances driven by the same stimulus.
module tb_sync_fifo_lvl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, flush_i = 1'b0, clr_err_i = 1'b0;
  logic        wr_en_i = 1'b0, rd_en_i = 1'b0;
  logic [15:0] wdata_i = '0;

  logic        f_wfull, f_af, f_rvalid, f_rempty, f_ae, f_ovf, f_udf;
  logic [15:0] f_rdata;
  logic [4:0]  f_level;
  logic        r_wfull, r_af, r_rvalid, r_rempty, r_ae, r_ovf, r_udf;
  logic [15:0] r_rdata;
  logic [4:0]  r_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1),
                  .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fw (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
    .wr_en_i(wr_en_i), .wdata_i(wdata_i), .wfull_o(f_wfull), .almost_full_o(f_af),
    .rd_en_i(rd_en_i), .rdata_o(f_rdata), .rvalid_o(f_rvalid), .rempty_o(f_rempty),
    .almost_empty_o(f_ae), .level_o(f_level), .overflow_o(f_ovf), .underflow_o(f_udf));

  sync_fifo_lvl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0),
                  .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_rg (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
    .wr_en_i(wr_en_i), .wdata_i(wdata_i), .wfull_o(r_wfull), .almost_full_o(r_af),
    .rd_en_i(rd_en_i), .rdata_o(r_rdata), .rvalid_o(r_rvalid), .rempty_o(r_rempty),
    .almost_empty_o(r_ae), .level_o(r_level), .overflow_o(r_ovf), .underflow_o(r_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of push/pop requests, sample 1ns after the edge.
  task automatic cyc(input logic wr, input logic [15:0] wd, input logic rd);
    wr_en_i = wr;
    wdata_i = wd;
    rd_en_i = rd;
    @(posedge clk);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  // Status expected from the stored-entry count (DEPTH 16, thresholds 12/2).
  task automatic chk_lvl(input string tag, input int lvl);
    chk({tag, ".level_fw"}, 32'(f_level), 32'(lvl));
    chk({tag, ".level_rg"}, 32'(r_level), 32'(lvl));
    chk({tag, ".full"},     32'(f_wfull), 32'(lvl == 16));
    chk({tag, ".empty"},    32'(f_rempty), 32'(lvl == 0));
    chk({tag, ".afull"},    32'(f_af),    32'(lvl >= 12));
    chk({tag, ".aempty"},   32'(f_ae),    32'(lvl <= 2));
    chk({tag, ".fw_rvalid"}, 32'(f_rvalid), 32'(lvl != 0));
  endtask

  task automatic chk_reset(input string tag);
    chk_lvl(tag, 0);
    chk({tag, ".ovf"},       32'(f_ovf),    32'd0);
    chk({tag, ".udf"},       32'(f_udf),    32'd0);
    chk({tag, ".rg_ovf"},    32'(r_ovf),    32'd0);
    chk({tag, ".rg_rvalid"}, 32'(r_rvalid), 32'd0);
    chk({tag, ".rg_rdata"},  32'(r_rdata),  32'd0);
    chk({tag, ".rg_empty"},  32'(r_rempty), 32'd1);
  endtask

  initial begin
    // Reset
    reset_i = 1'b1;
    cyc(1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    reset_i = 1'b0;
    chk_reset("reset");

    // 1: fill to full, then push into a full FIFO
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 16'(i), 1'b0);
      chk_lvl("fill", i);
      chk("fill.head", 32'(f_rdata), 32'h1);
    end
    cyc(1'b1, 16'hDEAD, 1'b0);
    chk_lvl("ovf", 16);
    chk("ovf.flag", 32'(f_ovf), 32'd1);
    chk("ovf.rg_flag", 32'(r_ovf), 32'd1);
    chk("ovf.udf", 32'(f_udf), 32'd0);

    // 2: drain in order, then pop from empty, then clear errors
    for (int i = 1; i <= 16; i++) begin
      chk("drain.fw_data", 32'(f_rdata), 32'(i));
      cyc(1'b0, 16'h0, 1'b1);
      chk("drain.rg_valid", 32'(r_rvalid), 32'd1);
      chk("drain.rg_data", 32'(r_rdata), 32'(i));
    end
    chk_lvl("drained", 0);
    cyc(1'b0, 16'h0, 1'b1);
    chk("udf.flag", 32'(f_udf), 32'd1);
    chk("udf.ovf_kept", 32'(f_ovf), 32'd1);
    chk("udf.rg_valid", 32'(r_rvalid), 32'd0);
    chk("udf.rg_hold", 32'(r_rdata), 32'h10);
    clr_err_i = 1'b1;
    cyc(1'b0, 16'h0, 1'b0);
    clr_err_i = 1'b0;
    chk("clr.ovf", 32'(f_ovf), 32'd0);
    chk("clr.udf", 32'(f_udf), 32'd0);

    // 3: almost-full and almost-empty thresholds
    for (int i = 0; i < 12; i++) cyc(1'b1, 16'(16'h100 + i), 1'b0);
    chk_lvl("thr12", 12);
    for (int i = 0; i < 9; i++) cyc(1'b0, 16'h0, 1'b1);
    chk_lvl("thr3", 3);
    cyc(1'b0, 16'h0, 1'b1);
    chk_lvl("thr2", 2);
    chk("thr2.rg_data", 32'(r_rdata), 32'h109);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    chk_lvl("thr0", 0);

    // 4: steady level 8 with simultaneous push+pop across pointer wraps
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h200 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("steady.fw_head", 32'(f_rdata), 32'(16'h200 + k));
      cyc(1'b1, 16'(16'h208 + k), 1'b1);
      chk("steady.level", 32'(f_level), 32'd8);
      chk("steady.rg_data", 32'(r_rdata), 32'(16'h200 + k));
    end
    for (int k = 40; k < 48; k++) begin
      chk("tail.fw_head", 32'(f_rdata), 32'(16'h200 + k));
      cyc(1'b0, 16'h0, 1'b1);
    end
    chk_lvl("tail", 0);
    // push+pop while empty: push taken, pop refused
    cyc(1'b1, 16'h300, 1'b1);
    chk_lvl("pp_empty", 1);
    chk("pp_empty.udf", 32'(f_udf), 32'd1);
    chk("pp_empty.rg_valid", 32'(r_rvalid), 32'd0);
    chk("pp_empty.fw_head", 32'(f_rdata), 32'h300);
    for (int i = 1; i < 16; i++) cyc(1'b1, 16'(16'h300 + i), 1'b0);
    chk_lvl("refill", 16);
    // push+pop while full: pop taken, push refused
    cyc(1'b1, 16'h3FF, 1'b1);
    chk_lvl("pp_full", 15);
    chk("pp_full.ovf", 32'(f_ovf), 32'd1);
    chk("pp_full.rg_valid", 32'(r_rvalid), 32'd1);
    chk("pp_full.rg_data", 32'(r_rdata), 32'h300);

    // 5: registered read valid for exactly one cycle after a single pop
    cyc(1'b0, 16'h0, 1'b1);
    chk("single.rg_valid", 32'(r_rvalid), 32'd1);
    chk("single.rg_data", 32'(r_rdata), 32'h301);
    cyc(1'b0, 16'h0, 1'b0);
    chk("idle.rg_valid", 32'(r_rvalid), 32'd0);
    chk("idle.rg_hold", 32'(r_rdata), 32'h301);
    chk_lvl("idle", 14);

    // 6: flush at level 5 with push+pop requested, errors retained
    for (int i = 0; i < 9; i++) cyc(1'b0, 16'h0, 1'b1);
    chk_lvl("preflush", 5);
    chk("preflush.fw_head", 32'(f_rdata), 32'h30B);
    flush_i = 1'b1;
    cyc(1'b1, 16'hBAD, 1'b1);
    flush_i = 1'b0;
    chk_lvl("flush", 0);
    chk("flush.rg_valid", 32'(r_rvalid), 32'd0);
    chk("flush.ovf", 32'(f_ovf), 32'd1);
    chk("flush.udf", 32'(f_udf), 32'd1);
    cyc(1'b1, 16'h400, 1'b0);
    chk_lvl("postflush", 1);
    chk("postflush.fw_head", 32'(f_rdata), 32'h400);
    cyc(1'b1, 16'h401, 1'b0);
    cyc(1'b1, 16'h402, 1'b0);
    // reset mid-stream with a pop requested in the same cycle
    reset_i = 1'b1;
    cyc(1'b1, 16'h403, 1'b1);
    reset_i = 1'b0;
    chk_reset("midreset");
    cyc(1'b0, 16'h0, 1'b0);
    chk_reset("midreset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
